// File: rtl/pc_word_packer.sv
// pc_word_packer: packs coded PC words into host words and pads stalled partial
// blocks with NOP words so the host always reads whole blocks.
module pc_word_packer #(
  parameter int NPCcode = 7,
  parameter int NPCdata = 20,
  parameter int Nout = 32,
  parameter int BlockWords = 256,
  parameter int TimeoutCycles = 4096,
  parameter logic [NPCcode-1:0] NOPCode = 7'h7F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NPCcode-1:0] in_code,
  input  logic [NPCdata-1:0] in_payload,
  input  logic               in_v,
  output logic               in_a,
  output logic [Nout-1:0]    out_d,
  output logic               out_v,
  input  logic               out_a,
  output logic               block_done
);
  localparam int CW = $clog2(BlockWords);
  localparam int IW = $clog2(TimeoutCycles + 1);
  localparam logic FILL = 1'b0;
  localparam logic PAD = 1'b1;

  logic            state_q, state_d;
  logic [CW-1:0]   load_cnt_q, load_cnt_d, out_cnt_q, out_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            out_v_q, out_v_d, block_done_q, block_done_d;
  logic [Nout-1:0] out_d_q, out_d_d;
  logic            free, in_xfer, pad_load, load, out_xfer, idle, timeout, load_wrap, out_wrap;

  assign free      = !out_v_q || out_a;
  assign in_a      = !reset && state_q == FILL && free;
  assign in_xfer   = in_v && in_a;
  assign pad_load  = state_q == PAD && free;
  assign load      = in_xfer || pad_load;
  assign out_xfer  = out_v_q && out_a;
  assign load_wrap = load_cnt_q == CW'(BlockWords - 1);
  assign out_wrap  = out_cnt_q == CW'(BlockWords - 1);
  // Backpressured cycles (in_v high) are not idle; an empty block never times out.
  assign idle      = state_q == FILL && !in_v && load_cnt_q != '0;
  assign timeout   = idle && idle_cnt_q == IW'(TimeoutCycles - 1);

  always_comb begin
    state_d      = timeout ? PAD : (pad_load && load_wrap) ? FILL : state_q;
    load_cnt_d   = !load ? load_cnt_q : load_wrap ? '0 : load_cnt_q + CW'(1);
    out_cnt_d    = !out_xfer ? out_cnt_q : out_wrap ? '0 : out_cnt_q + CW'(1);
    idle_cnt_d   = (in_xfer || timeout) ? '0 : idle ? idle_cnt_q + IW'(1) : idle_cnt_q;
    out_v_d      = load || (out_v_q && !out_a);
    out_d_d      = in_xfer ? Nout'({in_code, in_payload}) :
                   pad_load ? Nout'({NOPCode, {NPCdata{1'b0}}}) : out_d_q;
    block_done_d = out_xfer && out_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      load_cnt_q   <= '0;
      out_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      out_v_q      <= 1'b0;
      out_d_q      <= '0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      out_cnt_q    <= out_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      out_v_q      <= out_v_d;
      out_d_q      <= out_d_d;
      block_done_q <= block_done_d;
    end
  end

  assign out_v      = out_v_q;
  assign out_d      = out_d_q;
  assign block_done = block_done_q;
endmodule

// File: tb/tb_pc_word_packer.sv
// tb_pc_word_packer: directed scenarios with random data, scored against a
// block/timeout reference model that predicts the expected output stream.
module tb_pc_word_packer;
  localparam int BW = 4;
  localparam int TO = 8;
  localparam logic [31:0] NOP = 32'h07F00000;

  logic        clk = 0, reset = 1, in_v = 0, out_a = 1, rand_oa = 0;
  logic [6:0]  in_code = '0;
  logic [19:0] in_payload = '0;
  logic        in_a, out_v, block_done;
  logic [31:0] out_d, exp_w;
  int          tests = 0, fails = 0, nop_seen = 0, bd_seen = 0, n0 = 0, b0 = 0;
  int          n_loaded = 0, n_out = 0, idle = 0, pad_left = 0;
  logic        exp_bd = 0;
  logic [31:0] exp_q[$];

  pc_word_packer #(.BlockWords(BW), .TimeoutCycles(TO)) dut (
    .clk(clk), .reset(reset), .in_code(in_code), .in_payload(in_payload),
    .in_v(in_v), .in_a(in_a), .out_d(out_d), .out_v(out_v), .out_a(out_a),
    .block_done(block_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_oa) out_a = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic rnd_word();
    in_code = 7'($urandom_range(0, 126));
    in_payload = 20'($urandom);
  endtask

  task automatic send();
    in_v = 1;
    #1;
    for (int i = 0; i < 300 && !in_a; i++) step();
    tests++;
    assert (in_a) else begin
      fails++;
      $error("FAIL send_timeout: observed in_a=%b expected 1", in_a);
    end
    step();
    in_v = 0;
  endtask

  // Reference model: a block holds BW words; after TO idle cycles in a partial
  // block the remainder is owed as NOPs, loaded one per free register slot.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_a_reset", 32'(in_a), 0);
      exp_q.delete();
      n_loaded = 0; n_out = 0; idle = 0; pad_left = 0; exp_bd = 0;
    end else begin
      chk("in_a", 32'(in_a), 32'(pad_left == 0 && (!out_v || out_a)));
      chk("block_done", 32'(block_done), 32'(exp_bd));
      if (block_done) bd_seen++;
      exp_bd = 0;
      if (out_v && out_a) begin
        if (out_d == NOP) nop_seen++;
        n_out++;
        exp_bd = (n_out % BW == 0);
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL out_order: observed %h expected <no word>", out_d);
        end
        if (exp_q.size() > 0) chk("out_d", out_d, exp_q.pop_front());
      end
      if (pad_left > 0) begin
        if (!out_v || out_a) pad_left--;
      end else if (in_v && in_a) begin
        exp_q.push_back({5'd0, in_code, in_payload});
        n_loaded++;
        idle = 0;
      end else if (!in_v && n_loaded % BW != 0) begin
        idle++;
        if (idle == TO) begin
          pad_left = BW - n_loaded % BW;
          n_loaded += pad_left;
          idle = 0;
          repeat (pad_left) exp_q.push_back(NOP);
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_out_v", 32'(out_v), 0);
    chk("rst_out_d", out_d, 0);
    chk("rst_bd", 32'(block_done), 0);
    chk("rst_in_a", 32'(in_a), 0);
    reset = 0;
    step();
    // single word, then timed padding of the remaining 3 slots
    in_code = 7'd14; in_payload = 20'h12345;
    send();
    chk("lat_out_v", 32'(out_v), 1);
    chk("lat_out_d", out_d, 32'h00E12345);
    for (int i = 1; i <= TO; i++) begin
      step();
      chk("no_early_nop", 32'(out_v), 0);
    end
    chk("pad_in_a", 32'(in_a), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nop_v", 32'(out_v), 1);
      chk("nop_d", out_d, NOP);
    end
    step();
    chk("pad_end_v", 32'(out_v), 0);
    chk("pad_end_bd", 32'(block_done), 1);
    chk("pad_end_in_a", 32'(in_a), 1);
    step();
    // full block back-to-back
    b0 = bd_seen; n0 = nop_seen;
    in_v = 1;
    for (int i = 0; i < BW; i++) begin
      rnd_word();
      step();
    end
    in_v = 0;
    repeat (20) step();
    chk("b2b_bd", bd_seen - b0, 1);
    chk("b2b_nop", nop_seen - n0, 0);
    // random backpressure through padding
    b0 = bd_seen; n0 = nop_seen;
    rand_oa = 1;
    rnd_word();
    send();
    repeat (100) step();
    rand_oa = 0; out_a = 1;
    repeat (20) step();
    chk("rnd_nop", nop_seen - n0, 3);
    chk("rnd_bd", bd_seen - b0, 1);
    chk("rnd_drain", exp_q.size(), 0);
    // blocked input is not idle
    n0 = nop_seen;
    out_a = 0;
    rnd_word();
    send();
    rnd_word();
    in_v = 1;
    repeat (100) step();
    chk("blk_in_a", 32'(in_a), 0);
    chk("blk_nop", nop_seen - n0, 0);
    out_a = 1;
    send();
    repeat (30) step();
    chk("blk_pad_nop", nop_seen - n0, 2);
    chk("blk_drain", exp_q.size(), 0);
    // input arriving on the last idle cycle before timeout
    n0 = nop_seen;
    rnd_word();
    send();
    repeat (TO - 1) step();
    rnd_word();
    exp_w = {5'd0, in_code, in_payload};
    in_v = 1;
    step();
    in_v = 0;
    chk("edge_out_d", out_d, exp_w);
    chk("edge_nop", nop_seen - n0, 0);
    // reset in the middle of padding
    repeat (TO + 1) step();
    chk("pad_started", out_d, NOP);
    reset = 1;
    step();
    chk("midrst_out_v", 32'(out_v), 0);
    chk("midrst_out_d", out_d, 0);
    chk("midrst_in_a", 32'(in_a), 0);
    reset = 0;
    step();
    b0 = bd_seen; n0 = nop_seen;
    in_v = 1;
    for (int i = 0; i < BW; i++) begin
      rnd_word();
      step();
    end
    in_v = 0;
    repeat (20) step();
    chk("post_rst_bd", bd_seen - b0, 1);
    chk("post_rst_nop", nop_seen - n0, 0);
    chk("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
